wb_ram128_ctrl: RTL and testbench
=================================

// Module: wb_ram128_ctrl
// PURPOSE
//  Wishbone-classic slave that acts as the initiator for one RAM128 macro port
//  (EN0/WE0/A0/Di0/Do0) inside the user project area. It converts single WB
//  reads and writes into RAM enable/write-strobe pulses, waits out the macro's
//  registered read latency and returns data with a one-cycle ack.
// PARAMETERS
//  MEM_DEPTH  128          number of 32-bit words in the macro
//  ADDR_W     7            RAM word-address width; log2(MEM_DEPTH)
//  RD_LAT     1            clocks from the ram_en read pulse to valid ram_do (1..4)
//  BASE_ADDR  32'h3000_0000 WB byte-address base of the window
// PORTS
//  CLK        in   1      single clock; WB and RAM side share it
//  RST_N      in   1      asynchronous, active-low reset
//  wb_cyc_i   in   1      bus cycle valid
//  wb_stb_i   in   1      strobe; request when cyc&stb
//  wb_we_i    in   1      1=write, 0=read
//  wb_sel_i   in   4      byte lanes; bit n = bits [8n+7:8n]
//  wb_adr_i   in   32     byte address; word index = wb_adr_i[ADDR_W+1:2]
//  wb_dat_i   in   32     write data
//  wb_dat_o   out  32     read data, valid while wb_ack_o=1
//  wb_ack_o   out  1      one-cycle transfer acknowledge
//  wb_err_o   out  1      error response (RAMCTRL_OOR_ERR_EN only, else 0)
//  ram_en     out  1      to EN0; one-cycle pulse per access
//  ram_we     out  4      to WE0; byte write strobes, 0 on reads
//  ram_a      out  ADDR_W to A0
//  ram_di     out  32     to Di0
//  ram_do     in   32     from Do0
// BEHAVIOUR
//  - Reset (RST_N=0, async): all outputs 0, FSM=IDLE, latency counter=0.
//  - FSM: IDLE -> ISSUE -> (WAIT if read) -> ACK -> IDLE.
//  - IDLE: when wb_cyc_i&wb_stb_i, register adr index, dat, sel, we; go ISSUE.
//  - ISSUE (1 clk): ram_en=1, ram_a=latched index; write: ram_we=latched sel,
//    ram_di=latched data; read: ram_we=0. Write -> ACK; read -> WAIT.
//  - WAIT: count RD_LAT clocks from the ISSUE edge; on the final one capture
//    ram_do into wb_dat_o; go ACK.
//  - ACK (1 clk): wb_ack_o=1; next state is always IDLE.
//  - Latency from the accept edge: write ack in cycle +2; read ack in cycle
//    +2+RD_LAT (+3 at default).
//  - ram_en/ram_we are 0 outside ISSUE. ram_a/ram_di hold their last values.
//  - wb_dat_o holds the last read data until the next read capture.
//  - Write with wb_sel_i=0: no RAM access (ram_en stays 0); still acked in +2.
//  - Abort: if wb_cyc_i drops in ISSUE/WAIT, an already-issued RAM write still
//    completes; the ack is suppressed; return to IDLE on the next clock.
//    Read data is discarded and wb_dat_o is unchanged.
//  - stb is ignored outside IDLE. Back-to-back requests have at least one idle
//    clock between an ack and the next accept.
//  - Address upper bits above ADDR_W+1: see CONFIGURATION.
//  - Reset mid-transaction: immediate return to the reset state. Any pending
//    RAM pulse is dropped.
// CONFIGURATION
//  RAMCTRL_OOR_ERR_EN defined:
//   - accept checks wb_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
//   - on mismatch: no RAM access, wb_err_o=1 for one clk in cycle +2,
//     wb_ack_o stays 0.
//  Undefined: upper address bits ignored (aliasing), wb_err_o tied 0.
// TESTING
//  - Reset: RST_N low mid-read -> all outputs 0 at once, no ack after release.
//  - Write adr 0x3000_0010, dat 0xDEADBEEF, sel 4'hF ->
//    ram_en=1, ram_a=4, ram_we=F in +1; ack in +2.
//  - Read back adr 0x3000_0010 -> ram_en=1, ram_we=0 in +1;
//    ack with wb_dat_o=0xDEADBEEF in +3 (RD_LAT=1).
//  - Partial write sel 4'b0010, dat 0x0000_AB00 to the same word,
//    then read -> 0xDEADABEF.
//  - cyc dropped in WAIT -> no ack; the next read is accepted
//    and completes normally.
//  - OOR_ERR_EN: read at 0x4000_0000 -> wb_err_o pulse in +2, no ram_en, no ack;
//    macro undefined -> aliases to word 0 with ack.

Source files
------------

// File: rtl/wb_ram128_ctrl.sv
// rtl/wb_ram128_ctrl.sv - Wishbone-classic slave issuing single accesses to one RAM128 macro port
// Optional out-of-range error response enabled by defining RAMCTRL_OOR_ERR_EN.
module wb_ram128_ctrl #(
    parameter int          MEM_DEPTH = 128,
    parameter int          ADDR_W    = 7,
    parameter int          RD_LAT    = 1,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_a,
    output logic [31:0]       ram_di,
    input  logic [31:0]       ram_do
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    state_t            state;
    logic              we_q;
    logic              oor_q;
    logic [1:0]        lat_cnt;
    logic              req;
    logic              req_oor;
    logic [ADDR_W-1:0] req_idx;
    logic              unused_adr;

    assign req     = wb_cyc_i & wb_stb_i;
    assign req_idx = wb_adr_i[ADDR_W+1:2];

`ifdef RAMCTRL_OOR_ERR_EN
    assign req_oor    = (wb_adr_i[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);
    assign unused_adr = ^wb_adr_i[1:0];
`else
    // Upper address bits are ignored, so the window aliases across the bus.
    assign req_oor    = 1'b0;
    assign unused_adr = ^{wb_adr_i[31:ADDR_W+2], wb_adr_i[1:0]};
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            we_q     <= 1'b0;
            oor_q    <= 1'b0;
            lat_cnt  <= 2'd0;
            wb_dat_o <= 32'd0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            ram_en   <= 1'b0;
            ram_we   <= 4'd0;
            ram_a    <= '0;
            ram_di   <= 32'd0;
        end else begin
            ram_en   <= 1'b0;
            ram_we   <= 4'd0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q  <= wb_we_i;
                        oor_q <= req_oor;
                        state <= S_ISSUE;
                        if (!req_oor) begin
                            ram_a <= req_idx;
                            if (wb_we_i) begin
                                ram_di <= wb_dat_i;
                                ram_we <= wb_sel_i;
                                ram_en <= |wb_sel_i;
                            end else begin
                                ram_en <= 1'b1;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    // The RAM pulse has already gone out; an abort only drops the response.
                    if (!wb_cyc_i) begin
                        state <= S_IDLE;
                    end else if (oor_q) begin
                        wb_err_o <= 1'b1;
                        state    <= S_ACK;
                    end else if (we_q) begin
                        wb_ack_o <= 1'b1;
                        state    <= S_ACK;
                    end else begin
                        lat_cnt <= 2'd0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!wb_cyc_i) begin
                        lat_cnt <= 2'd0;
                        state   <= S_IDLE;
                    end else if (lat_cnt == LAT_LAST) begin
                        wb_dat_o <= ram_do;
                        wb_ack_o <= 1'b1;
                        lat_cnt  <= 2'd0;
                        state    <= S_ACK;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_ram128_ctrl.sv
// tb/tb_wb_ram128_ctrl.sv - scoreboard testbench for wb_ram128_ctrl with a RAM128 behavioural model
module tb_wb_ram128_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic [31:0] adr = 32'd0, dat = 32'd0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [6:0]  ram_a;
    logic [31:0] ram_di;
    logic [31:0] ram_do = 32'd0;

    logic [31:0] mem [128] = '{default: 32'd0};
    logic [31:0] model [128] = '{default: 32'd0};
    logic [31:0] exp_q [$];
    logic [31:0] last_rd = 32'd0;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 CLK = ~CLK;

    wb_ram128_ctrl dut (
        .CLK(CLK), .RST_N(RST_N),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
        .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a),
        .ram_di(ram_di), .ram_do(ram_do)
    );

    // RAM128 macro: registered read, one clock of latency, byte write strobes
    always @(posedge CLK) begin
        if (ram_en) begin
            if (ram_we == 4'd0) ram_do <= mem[ram_a];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
        end
    end

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) model[a[8:2]][8*b +: 8] = d[8*b +: 8];
    endfunction

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int lat, output int en_cnt, output logic [3:0] we1,
                           output logic [6:0] a1, output logic [31:0] dato,
                           output logic err_seen, output logic ack_seen);
        @(negedge CLK);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        lat = -1; en_cnt = 0; we1 = 4'd0; a1 = 7'd0; dato = 32'd0;
        err_seen = 1'b0; ack_seen = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            if (ram_en) begin en_cnt++; we1 = ram_we; a1 = ram_a; end
            if (wb_ack_o || wb_err_o) begin
                lat = c; dato = wb_dat_o;
                err_seen = wb_err_o; ack_seen = wb_ack_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        n_total++;
        if ({wb_ack_o, wb_err_o, ram_en, ram_we, ram_a, ram_di, wb_dat_o} !== '0)
            $display("FAIL reset_outputs: got ack=%b err=%b en=%b we=%h a=%h di=%h do=%h want all 0",
                     wb_ack_o, wb_err_o, ram_en, ram_we, ram_a, ram_di, wb_dat_o);
        else n_pass++;
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        n_total++;
        if ({wb_ack_o, ram_en} !== 2'b00) $display("FAIL reset_idle: got ack=%b en=%b want 0 0", wb_ack_o, ram_en);
        else n_pass++;
    endtask

    task automatic test_write;
        int lat, en_cnt; logic [3:0] we1; logic [6:0] a1; logic [31:0] dato; logic e, k;
        model_write(32'h3000_0010, 32'hDEAD_BEEF, 4'hF);
        wb_xfer(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, lat, en_cnt, we1, a1, dato, e, k);
        n_total++; if (lat !== 2) $display("FAIL wr_ack_lat: got %0d want 2", lat); else n_pass++;
        n_total++; if (en_cnt !== 1) $display("FAIL wr_en_pulses: got %0d want 1", en_cnt); else n_pass++;
        n_total++; if (we1 !== 4'hF) $display("FAIL wr_ram_we: got %h want f", we1); else n_pass++;
        n_total++; if (a1 !== 7'd4) $display("FAIL wr_ram_a: got %0d want 4", a1); else n_pass++;
    endtask

    task automatic test_read;
        int lat, en_cnt; logic [3:0] we1; logic [6:0] a1; logic [31:0] dato, exp; logic e, k;
        exp_q.push_back(model[4]);
        wb_xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, lat, en_cnt, we1, a1, dato, e, k);
        exp = exp_q.pop_front();
        n_total++; if (lat !== 3) $display("FAIL rd_ack_lat: got %0d want 3", lat); else n_pass++;
        n_total++; if (en_cnt !== 1) $display("FAIL rd_en_pulses: got %0d want 1", en_cnt); else n_pass++;
        n_total++; if (we1 !== 4'h0) $display("FAIL rd_ram_we: got %h want 0", we1); else n_pass++;
        n_total++; if (a1 !== 7'd4) $display("FAIL rd_ram_a: got %0d want 4", a1); else n_pass++;
        n_total++; if (dato !== exp) $display("FAIL rd_data: got %h want %h", dato, exp); else n_pass++;
        last_rd = exp;
    endtask

    task automatic test_partial;
        int lat, en_cnt; logic [3:0] we1; logic [6:0] a1; logic [31:0] dato, exp; logic e, k;
        model_write(32'h3000_0010, 32'h0000_AB00, 4'b0010);
        wb_xfer(1'b1, 32'h3000_0010, 32'h0000_AB00, 4'b0010, lat, en_cnt, we1, a1, dato, e, k);
        n_total++; if (we1 !== 4'b0010) $display("FAIL part_ram_we: got %h want 2", we1); else n_pass++;
        exp_q.push_back(model[4]);
        wb_xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, lat, en_cnt, we1, a1, dato, e, k);
        exp = exp_q.pop_front();
        n_total++; if (dato !== exp) $display("FAIL part_data: got %h want %h", dato, exp); else n_pass++;
        n_total++; if (dato !== 32'hDEAD_ABEF) $display("FAIL part_value: got %h want deadabef", dato); else n_pass++;
        last_rd = exp;
    endtask

    task automatic test_sel_zero;
        int lat, en_cnt; logic [3:0] we1; logic [6:0] a1; logic [31:0] dato, exp; logic e, k;
        model_write(32'h3000_0014, 32'h1357_9BDF, 4'hF);
        wb_xfer(1'b1, 32'h3000_0014, 32'h1357_9BDF, 4'hF, lat, en_cnt, we1, a1, dato, e, k);
        wb_xfer(1'b1, 32'h3000_0014, 32'hFFFF_FFFF, 4'h0, lat, en_cnt, we1, a1, dato, e, k);
        n_total++; if (en_cnt !== 0) $display("FAIL sel0_en_pulses: got %0d want 0", en_cnt); else n_pass++;
        n_total++; if (lat !== 2) $display("FAIL sel0_ack_lat: got %0d want 2", lat); else n_pass++;
        exp_q.push_back(model[5]);
        wb_xfer(1'b0, 32'h3000_0014, 32'h0, 4'hF, lat, en_cnt, we1, a1, dato, e, k);
        exp = exp_q.pop_front();
        n_total++; if (dato !== exp) $display("FAIL sel0_data: got %h want %h", dato, exp); else n_pass++;
        last_rd = exp;
    endtask

    task automatic test_abort;
        int lat, en_cnt, acks; logic [3:0] we1; logic [6:0] a1; logic [31:0] dato, exp; logic e, k;
        model_write(32'h3000_0024, 32'hCAFE_F00D, 4'hF);
        wb_xfer(1'b1, 32'h3000_0024, 32'hCAFE_F00D, 4'hF, lat, en_cnt, we1, a1, dato, e, k);
        // read dropped while waiting for the macro
        @(negedge CLK);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0024; sel = 4'hF;
        @(negedge CLK);
        @(negedge CLK);
        cyc = 1'b0; stb = 1'b0;
        acks = 0;
        repeat (5) begin @(negedge CLK); if (wb_ack_o) acks++; end
        n_total++; if (acks !== 0) $display("FAIL abort_rd_ack: got %0d acks want 0", acks); else n_pass++;
        n_total++; if (wb_dat_o !== last_rd) $display("FAIL abort_rd_dat_hold: got %h want %h", wb_dat_o, last_rd); else n_pass++;
        exp_q.push_back(model[9]);
        wb_xfer(1'b0, 32'h3000_0024, 32'h0, 4'hF, lat, en_cnt, we1, a1, dato, e, k);
        exp = exp_q.pop_front();
        n_total++; if (lat !== 3) $display("FAIL after_abort_lat: got %0d want 3", lat); else n_pass++;
        n_total++; if (dato !== exp) $display("FAIL after_abort_data: got %h want %h", dato, exp); else n_pass++;
        last_rd = exp;
        // write dropped in ISSUE still lands in the macro
        model_write(32'h3000_0028, 32'h5A5A_A5A5, 4'hF);
        @(negedge CLK);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0028; dat = 32'h5A5A_A5A5; sel = 4'hF;
        @(negedge CLK);
        cyc = 1'b0; stb = 1'b0;
        acks = 0;
        repeat (4) begin @(negedge CLK); if (wb_ack_o) acks++; end
        n_total++; if (acks !== 0) $display("FAIL abort_wr_ack: got %0d acks want 0", acks); else n_pass++;
        exp_q.push_back(model[10]);
        wb_xfer(1'b0, 32'h3000_0028, 32'h0, 4'hF, lat, en_cnt, we1, a1, dato, e, k);
        exp = exp_q.pop_front();
        n_total++; if (dato !== exp) $display("FAIL abort_wr_data: got %h want %h", dato, exp); else n_pass++;
        last_rd = exp;
    endtask

    task automatic test_alias;
        int lat, en_cnt; logic [3:0] we1; logic [6:0] a1; logic [31:0] dato, exp; logic e, k;
        model_write(32'h3000_0000, 32'h0BAD_F00D, 4'hF);
        wb_xfer(1'b1, 32'h3000_0000, 32'h0BAD_F00D, 4'hF, lat, en_cnt, we1, a1, dato, e, k);
`ifdef RAMCTRL_OOR_ERR_EN
        wb_xfer(1'b0, 32'h4000_0000, 32'h0, 4'hF, lat, en_cnt, we1, a1, dato, e, k);
        n_total++; if (lat !== 2) $display("FAIL oor_err_lat: got %0d want 2", lat); else n_pass++;
        n_total++; if (e !== 1'b1) $display("FAIL oor_err: got %b want 1", e); else n_pass++;
        n_total++; if (k !== 1'b0) $display("FAIL oor_ack: got %b want 0", k); else n_pass++;
        n_total++; if (en_cnt !== 0) $display("FAIL oor_en_pulses: got %0d want 0", en_cnt); else n_pass++;
`else
        exp_q.push_back(model[0]);
        wb_xfer(1'b0, 32'h4000_0000, 32'h0, 4'hF, lat, en_cnt, we1, a1, dato, e, k);
        exp = exp_q.pop_front();
        n_total++; if (lat !== 3) $display("FAIL alias_lat: got %0d want 3", lat); else n_pass++;
        n_total++; if (k !== 1'b1 || e !== 1'b0) $display("FAIL alias_resp: got ack=%b err=%b want 1 0", k, e); else n_pass++;
        n_total++; if (a1 !== 7'd0) $display("FAIL alias_ram_a: got %0d want 0", a1); else n_pass++;
        n_total++; if (dato !== exp) $display("FAIL alias_data: got %h want %h", dato, exp); else n_pass++;
        last_rd = exp;
`endif
    endtask

    task automatic test_back_to_back;
        int wr_lat, en_at, ack_at, idle_en; logic [31:0] dato, exp;
        model_write(32'h3000_0030, 32'h600D_CAFE, 4'hF);
        exp_q.push_back(model[12]);
        @(negedge CLK);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0030; dat = 32'h600D_CAFE; sel = 4'hF;
        wr_lat = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            if (wb_ack_o) begin wr_lat = c; break; end
        end
        we = 1'b0;
        en_at = -1; ack_at = -1; idle_en = 0; dato = 32'd0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            if (c == 1 && (ram_en || wb_ack_o)) idle_en = 1;
            if (ram_en && en_at < 0) en_at = c;
            if (wb_ack_o) begin ack_at = c; dato = wb_dat_o; break; end
        end
        cyc = 1'b0; stb = 1'b0;
        exp = exp_q.pop_front();
        n_total++; if (wr_lat !== 2) $display("FAIL b2b_wr_lat: got %0d want 2", wr_lat); else n_pass++;
        n_total++; if (idle_en !== 0) $display("FAIL b2b_idle_gap: got activity=%0d want 0", idle_en); else n_pass++;
        n_total++; if (en_at !== 2) $display("FAIL b2b_rd_issue: got %0d want 2", en_at); else n_pass++;
        n_total++; if (ack_at !== 4) $display("FAIL b2b_rd_ack: got %0d want 4", ack_at); else n_pass++;
        n_total++; if (dato !== exp) $display("FAIL b2b_data: got %h want %h", dato, exp); else n_pass++;
        last_rd = exp;
    endtask

    task automatic test_reset_midread;
        int acts;
        @(negedge CLK);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0010; sel = 4'hF;
        @(negedge CLK);
        n_total++; if (ram_en !== 1'b1) $display("FAIL mid_rd_issue: got %b want 1", ram_en); else n_pass++;
        #2 RST_N = 1'b0;
        #1;
        n_total++;
        if ({wb_ack_o, wb_err_o, ram_en, ram_we, ram_a, ram_di, wb_dat_o} !== '0)
            $display("FAIL mid_rd_reset: got ack=%b err=%b en=%b we=%h a=%h di=%h do=%h want all 0",
                     wb_ack_o, wb_err_o, ram_en, ram_we, ram_a, ram_di, wb_dat_o);
        else n_pass++;
        cyc = 1'b0; stb = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        acts = 0;
        repeat (5) begin @(negedge CLK); if (wb_ack_o || ram_en) acts++; end
        n_total++; if (acts !== 0) $display("FAIL mid_rd_post_reset: got %0d active cycles want 0", acts); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_partial();
        test_sel_zero();
        test_abort();
        test_alias();
        test_back_to_back();
        test_reset_midread();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
